// File: rtl/tdes_key_sched_if.sv
// Key-load and single-DES control bundle for tdes_key_sched.
// slave = scheduler side, master = driver side.
interface tdes_key_sched_if;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        key_clear;
  logic        start;
  logic        mode;
  logic        des_done;
  logic [63:0] key_out;
  logic        des_start;
  logic        des_decrypt;
  logic [1:0]  stage;
  logic        busy;
  logic        done;
  logic        keys_valid;
  logic        key_err;
  logic        timeout_err;

  modport slave (
    input  byte_valid, byte_data, key_clear,
    input  start, mode, des_done,
    output byte_ready, key_out, des_start,
    output des_decrypt, stage, busy, done,
    output keys_valid, key_err, timeout_err
  );

  modport master (
    output byte_valid, byte_data, key_clear,
    output start, mode, des_done,
    input  byte_ready, key_out, des_start,
    input  des_decrypt, stage, busy, done,
    input  keys_valid, key_err, timeout_err
  );
endinterface

// File: rtl/tdes_key_sched.sv
// Triple-DES key loader and EDE stage sequencer.
// Optional odd-parity key check: define KEY_PARITY_CHECK_EN.
module tdes_key_sched #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input logic             clk,
  input logic             n_rst,
  tdes_key_sched_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE, LAUNCH, WAIT, FINISH
  } state_t;

  state_t        state, state_nx;
  logic [191:0]  kr;
  logic [4:0]    cnt;
  logic          mode_q;
  logic [1:0]    stg, stg_nx;
  logic [15:0]   wcnt;
  logic          tmo_q, tmo_nx;
  logic          kerr;
  logic          kvalid;
  logic          accept;
  logic          clr;
  logic          act;
  logic          sel_k1;
  logic          to_hit;
  logic [63:0]   key;

  assign kvalid = (cnt == 5'd24);
  assign accept = bus.byte_valid && bus.byte_ready;
  assign clr    = bus.key_clear && (state == IDLE);
  assign act    = (state == LAUNCH) || (state == WAIT);
  assign to_hit = (wcnt == 16'(TIMEOUT_CYCLES - 1));

  // Shift register: after 24 bytes, byte 0 sits in K1[63:56].
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      cnt <= '0;
      kr  <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= cnt + 5'd1;
      kr  <= {kr[183:0], bus.byte_data};
    end
  end

`ifdef KEY_PARITY_CHECK_EN
  always_ff @(posedge clk) begin
    if (!n_rst)
      kerr <= 1'b0;
    else if (clr)
      kerr <= 1'b0;
    else if (accept && !(^bus.byte_data))
      kerr <= 1'b1;
  end
`else
  assign kerr = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state  <= IDLE;
      stg    <= '0;
      mode_q <= 1'b0;
      wcnt   <= '0;
      tmo_q  <= 1'b0;
    end else begin
      state <= state_nx;
      stg   <= stg_nx;
      tmo_q <= tmo_nx;
      if (state == IDLE && state_nx == LAUNCH)
        mode_q <= bus.mode;
      if (state == LAUNCH)
        wcnt <= '0;
      else if (state == WAIT)
        wcnt <= wcnt + 16'd1;
    end
  end

  always_comb begin
    state_nx = state;
    stg_nx   = stg;
    tmo_nx   = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start && kvalid && !kerr)
          state_nx = LAUNCH;
      end
      LAUNCH: state_nx = WAIT;
      WAIT: begin
        // des_done beats a same-cycle timeout
        if (bus.des_done) begin
          if (stg == 2'd2) begin
            state_nx = FINISH;
          end else begin
            stg_nx   = stg + 2'd1;
            state_nx = LAUNCH;
          end
        end else if (to_hit) begin
          state_nx = IDLE;
          stg_nx   = '0;
          tmo_nx   = 1'b1;
        end
      end
      FINISH: begin
        state_nx = IDLE;
        stg_nx   = '0;
      end
      default: begin
        state_nx = IDLE;
        stg_nx   = '0;
      end
    endcase
  end

  // Decrypt walks the keys in reverse: K3, K2, K1.
  assign sel_k1 = ((stg == 2'd0) && !mode_q) ||
                  ((stg == 2'd2) && mode_q);

  always_comb begin
    key = '0;
    unique case (1'b1)
      !act:                   key = '0;
      act && (stg == 2'd1):   key = kr[127:64];
      act && sel_k1:          key = kr[191:128];
      default:                key = kr[63:0];
    endcase
  end

  assign bus.byte_ready  = (state == IDLE) && !kvalid;
  assign bus.key_out     = key;
  assign bus.des_start   = (state == LAUNCH);
  assign bus.des_decrypt = act && (mode_q ^ (stg == 2'd1));
  assign bus.stage       = stg;
  assign bus.busy        = (state != IDLE);
  assign bus.done        = (state == FINISH);
  assign bus.keys_valid  = kvalid;
  assign bus.key_err     = kerr;
  assign bus.timeout_err = tmo_q;

endmodule

// File: doc/tdes_key_sched.md
TDES_KEY_SCHED -- requirements
Module: tdes_key_sched

Interface
REQ-001 The block SHALL have one parameter: TIMEOUT_CYCLES, 255, maximum cycles to wait for des_done per stage (range 1..65535).
REQ-002 The ports SHALL be as follows; one clock, and reset is synchronous and active-low:
  clk  in  1  system clock, all logic on rising edge
  n_rst  in  1  synchronous active-low reset
  byte_valid  in  1  key byte strobe from I2C receiver
  byte_data  in  8  key byte
  byte_ready  out  1  byte accepted this cycle when high with byte_valid
  key_clear  in  1  discard loaded key bytes
  start  in  1  begin one triple-DES block operation
  mode  in  1  0 = encrypt, 1 = decrypt, sampled with start
  des_done  in  1  single-DES core finished current stage
  key_out  out  64  key applied to single-DES core
  des_start  out  1  one-cycle launch pulse to single-DES core
  des_decrypt  out  1  direction for current stage
  stage  out  2  current stage 0..2
  busy  out  1  operation in progress
  done  out  1  one-cycle completion pulse
  keys_valid  out  1  all 24 key bytes loaded
  key_err  out  1  sticky key parity error
  timeout_err  out  1  one-cycle timeout pulse

Function
REQ-003 Key load SHALL store 24 bytes: bytes 0-7 -> K1, 8-15 -> K2, 16-23 -> K3, MSB byte first (byte 0 -> K1[63:56]).
REQ-004 byte_ready SHALL equal (FSM in IDLE) AND NOT keys_valid; bytes with byte_ready low SHALL be dropped.
REQ-005 keys_valid SHALL rise the cycle after byte 23 is accepted; the byte counter SHALL stop at 24, never wrapping.
REQ-006 key_clear SHALL zero byte counter, keys_valid and key_err next cycle; K1-K3 contents need not be zeroed; key_clear while busy SHALL be ignored.
REQ-007 Sequencer FSM states SHALL be IDLE, LAUNCH, WAIT, FINISH.
REQ-008 IDLE -> LAUNCH on start AND keys_valid AND NOT key_err; otherwise start SHALL be ignored; mode SHALL be latched on the accepting cycle.
REQ-009 LAUNCH SHALL assert des_start for exactly one cycle, then go to WAIT.
REQ-010 Stage order: encrypt = (K1,E),(K2,D),(K3,E); decrypt = (K3,D),(K2,E),(K1,D); des_decrypt high for D.
REQ-011 key_out, des_decrypt and stage SHALL be stable from LAUNCH until the stage ends; key_out = 0 in IDLE.
REQ-012 WAIT: des_done on stage 0 or 1 -> stage+1, LAUNCH; on stage 2 -> FINISH.
REQ-013 FINISH SHALL pulse done one cycle, then return to IDLE with stage = 0.
REQ-014 Latency: des_start asserts the cycle after start is accepted; done asserts the cycle after the final des_done.
REQ-015 A WAIT counter SHALL clear on entering WAIT; at TIMEOUT_CYCLES cycles without des_done the FSM SHALL pulse timeout_err and return to IDLE without done.
REQ-016 des_done and timeout in the same cycle: des_done SHALL win.
REQ-017 des_done outside WAIT SHALL be ignored; start while busy SHALL be ignored.
REQ-018 busy SHALL be high in LAUNCH, WAIT and FINISH.

Reset
REQ-019 With n_rst low at a clock edge: FSM = IDLE, byte counter = 0, keys_valid = 0, key_err = 0, all outputs 0 except byte_ready = 1, taking effect on that edge; reset mid-operation SHALL abort silently (no done, no timeout_err).

Configuration
REQ-020 Macro KEY_PARITY_CHECK_EN defined: each accepted byte SHALL be checked for odd parity; any even-parity byte sets key_err sticky until key_clear or reset, blocking start.
REQ-021 KEY_PARITY_CHECK_EN undefined: key_err SHALL be constant 0 and no parity logic synthesised.

Verification
REQ-022 Load 24 bytes 0x01..0x18 -> keys_valid=1 one cycle after byte 24; K1=0x0102030405060708, K3=0x1112131415161718; 25th byte ignored.
REQ-023 Encrypt, des_done 3 cycles after each des_start -> key_out K1/K2/K3, des_decrypt 0/1/0, done 1 cycle after third des_done.
REQ-024 Decrypt, same stimulus -> key_out K3/K2/K1, des_decrypt 1/0/1.
REQ-025 TIMEOUT_CYCLES=4, des_done withheld in stage 1 -> timeout_err pulse after 4 WAIT cycles, no done, IDLE; des_done coincident with 4th cycle -> stage advances, no timeout_err.
REQ-026 n_rst low during stage 1 WAIT -> next cycle busy=0, keys_valid=0, key_out=0, no done.
REQ-027 KEY_PARITY_CHECK_EN defined, byte 0x03 loaded -> key_err=1, start ignored; key_clear -> key_err=0.
